// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// RV32I instruction encoder and instruction-memory loader. Field-level
// instruction descriptions are encoded into 32-bit machine words, buffered in
// a small FIFO, and written sequentially into instruction memory.
//
// Optional feature macro: ENC_RANGE_CHECK_EN
//   defined   : immediates are range-checked per format; an out-of-range
//               instruction is consumed without being pushed and sets err.
//   undefined : immediates are truncated to the format's fields; err is only
//               set by an illegal in_fmt.
//
// Parameters:
//   DEPTH      FIFO entries (power of two, >= 2)
//   ADDR_WIDTH byte-address width of the memory port
//   BASE_ADDR  first write address of every session (word aligned)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               pulse, begins a load session from IDLE
//   in_valid/in_ready   instruction field handshake
//   in_last             final instruction of the session
//   in_fmt              000 I, 001 S, 010 B, 011 J, 100 U, 101 R
//   in_op, in_funct3, in_funct7_5, in_rd, in_rs1, in_rs2, in_imm  fields
//   mem_we/mem_ready    memory write handshake
//   mem_addr, mem_wdata byte address and word at the FIFO head
//   done                one-cycle pulse at session end
//   err, clr_err        sticky reject flag and its clear
//   dbg_state           current FSM state (0 IDLE, 1 LOAD, 2 DRAIN, 3 DONE)
//
// Handshakes: a beat transfers on a rising edge where valid and ready are
// both high; valid never depends on ready, and a source holding valid keeps
// its payload stable until the transfer.
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [2:0]            in_fmt,
    input  logic [6:0]            in_op,
    input  logic [2:0]            in_funct3,
    input  logic                  in_funct7_5,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [31:0]           in_imm,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  done,
    output logic                  err,
    input  logic                  clr_err,
    output logic [1:0]            dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  err_q, err_d;
    logic [31:0]           fifo_q [DEPTH];

    logic        fifo_empty, fifo_full;
    logic        accept, push, pop, reject;
    logic        fmt_legal, insn_ok;
    logic [31:0] enc_word;

    // ------------------------------------------------------------------
    // Encoder: standard RV32I bit placement per format.
    // ------------------------------------------------------------------
    always_comb begin
        enc_word  = 32'd0;
        fmt_legal = 1'b1;
        case (in_fmt)
            3'b000: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            3'b001: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:0], in_op};
            3'b010: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                                in_funct3, in_imm[4:1], in_imm[11], in_op};
            3'b011: enc_word = {in_imm[20], in_imm[10:1], in_imm[11],
                                in_imm[19:12], in_rd, in_op};
            3'b100: enc_word = {in_imm[31:12], in_rd, in_op};
            3'b101: enc_word = {1'b0, in_funct7_5, 5'b00000, in_rs2, in_rs1,
                                in_funct3, in_rd, in_op};
            default: fmt_legal = 1'b0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic range_ok;

    // A signed N-bit value has bits [31:N-1] all equal.
    always_comb begin
        range_ok = 1'b1;
        case (in_fmt)
            3'b000,
            3'b001: range_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
            3'b010: range_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
            3'b011: range_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
            3'b100: range_ok = !(|in_imm[11:0]);
            default: range_ok = 1'b1;
        endcase
    end

    assign insn_ok = fmt_legal && range_ok;
`else
    assign insn_ok = fmt_legal;
`endif

    // ------------------------------------------------------------------
    // FIFO status and handshakes
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign in_ready = (state_q == ST_LOAD) && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && insn_ok;
    assign reject   = accept && !insn_ok;
    assign pop      = mem_we && mem_ready;

    assign mem_we    = !fifo_empty;
    assign mem_addr  = addr_q;
    // Driven to zero when nothing is queued so the port never shows stale data.
    assign mem_wdata = fifo_empty ? 32'd0 : fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        addr_d   = addr_q;
        err_d    = err_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        // The FIFO is always empty in IDLE, so a restart never races a pop.
        if ((state_q == ST_IDLE) && start) begin
            addr_d = ADDR_WIDTH'(BASE_ADDR);
        end else if (pop) begin
            addr_d = addr_q + ADDR_WIDTH'(4);
        end

        // Clear wins over a same-cycle reject.
        if (clr_err) begin
            err_d = 1'b0;
        end else if (reject) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            // A rejected last instruction still ends the load phase.
            ST_LOAD:  if (accept && in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            addr_q   <= ADDR_WIDTH'(BASE_ADDR);
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: reading is masked by the pointers.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= enc_word;
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int BASE  = 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, in_valid, in_ready, in_last;
  logic [2:0]    in_fmt, in_funct3;
  logic [6:0]    in_op;
  logic          in_funct7_5;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          done, err, clr_err;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_fmt(in_fmt), .in_op(in_op),
    .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .err(err), .clr_err(clr_err), .dbg_state(dbg_state)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Words built by shifting/masking the immediate into place arithmetically.
  function automatic logic [31:0] ref_enc(input logic [2:0] fmt, input logic [6:0] op,
      input logic [2:0] f3, input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w, o, d, s1, s2, f;
    o  = 32'(op);
    d  = 32'(rd) << 7;
    s1 = 32'(rs1) << 15;
    s2 = 32'(rs2) << 20;
    f  = 32'(f3) << 12;
    case (fmt)
      3'd0: w = ((imm & 32'hFFF) << 20) | s1 | f | d | o;
      3'd1: w = (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | f | ((imm & 32'h1F) << 7) | o;
      3'd2: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 | f
                | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | o;
      3'd3: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | o;
      3'd4: w = (imm & 32'hFFFF_F000) | d | o;
      default: w = (32'(f7) << 30) | s2 | s1 | f | d | o;
    endcase
    return w;
  endfunction

  function automatic bit ref_ok(input logic [2:0] fmt, input logic [31:0] imm);
    int s;
    bit ok;
    s = $signed(imm);
    if (fmt > 3'd5) return 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    case (fmt)
      3'd0, 3'd1: ok = (s >= -2048) && (s <= 2047);
      3'd2:       ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      3'd3:       ok = (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
      3'd4:       ok = (imm % 4096) == 0;
      default:    ok = 1'b1;
    endcase
`else
    ok = 1'b1;
`endif
    return ok;
  endfunction

  typedef enum int {M_IDLE, M_LOAD, M_DRAIN, M_DONE} mphase_t;

  logic [31:0] exp_q[$];
  int          log_addr[$];
  logic [31:0] log_data[$];
  mphase_t     m_ph;
  int          m_addr;
  bit          m_err;

  // Model + scoreboard: checks every output each cycle, then advances.
  always @(negedge clk) begin
    bit exp_ready, acc;
    int sz;
    if (!rst_n) begin
      exp_q.delete();
      m_ph   = M_IDLE;
      m_addr = BASE;
      m_err  = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), BASE);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
    end else begin
      sz = exp_q.size();
      exp_ready = (m_ph == M_LOAD) && (sz < DEPTH);
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("mem_we", 32'(mem_we), 32'(sz != 0));
      chk("mem_addr", 32'(mem_addr), m_addr);
      chk("mem_wdata", mem_wdata, (sz != 0) ? exp_q[0] : 32'd0);
      chk("done", 32'(done), 32'(m_ph == M_DONE));
      chk("err", 32'(err), 32'(m_err));

      if (mem_we && mem_ready) begin
        log_addr.push_back(32'(mem_addr));
        log_data.push_back(mem_wdata);
      end
      if (sz != 0 && mem_ready) begin
        void'(exp_q.pop_front());
        m_addr = (m_addr + 4) % (1 << AW);
      end

      acc = in_valid && exp_ready;
      if (acc && ref_ok(in_fmt, in_imm))
        exp_q.push_back(ref_enc(in_fmt, in_op, in_funct3, in_funct7_5, in_rd, in_rs1, in_rs2, in_imm));
      if (clr_err) m_err = 1'b0;
      else if (acc && !ref_ok(in_fmt, in_imm)) m_err = 1'b1;

      case (m_ph)
        M_IDLE:  if (start) begin m_ph = M_LOAD; m_addr = BASE; end
        M_LOAD:  if (acc && in_last) m_ph = M_DRAIN;
        M_DRAIN: if (sz == 0) m_ph = M_DONE;
        default: m_ph = M_IDLE;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end at one time unit after a rising edge.
  task automatic start_session();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
      input logic f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm, input logic last);
    int waited = 0;
    in_valid = 1'b1; in_fmt = fmt; in_op = op; in_funct3 = f3; in_funct7_5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 500) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      if (n > 600) begin
        chk("done_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  function automatic logic [31:0] rand_imm(input logic [2:0] fmt);
    logic [31:0] r;
    if ($urandom_range(0, 3) == 0) return $urandom;
    case (fmt)
      3'd0, 3'd1: r = 32'($urandom_range(0, 4095)) - 32'd2048;
      3'd2:       r = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      3'd3:       r = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
      3'd4:       r = $urandom & 32'hFFFF_F000;
      default:    r = $urandom;
    endcase
    return r;
  endfunction

  bit stop_rand;

  initial begin
    int n0;
    logic [2:0] fmt;
    rst_n = 1'b0; start = 0; in_valid = 0; in_last = 0; in_fmt = 0; in_op = 0;
    in_funct3 = 0; in_funct7_5 = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
    mem_ready = 1'b1; clr_err = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // addi x1, x0, 5
    n0 = log_data.size();
    start_session();
    send(3'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    wait_done();
    chk("addi_cnt", log_data.size() - n0, 1);
    chk("addi_addr", log_addr[n0], 0);
    chk("addi_data", log_data[n0], 32'h0050_0093);

    // add, sub, sw, beq
    n0 = log_data.size();
    start_session();
    send(3'd5, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    send(3'd5, 7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    send(3'd1, 7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    send(3'd2, 7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, -32'sd4, 1'b1);
    wait_done();
    chk("rsb_cnt", log_data.size() - n0, 4);
    chk("add_data", log_data[n0], 32'h0020_81B3);
    chk("sub_data", log_data[n0+1], 32'h4020_81B3);
    chk("sub_addr", log_addr[n0+1], 4);
    chk("sw_data", log_data[n0+2], 32'h0020_A423);
    chk("beq_data", log_data[n0+3], 32'hFE00_0EE3);
    chk("beq_addr", log_addr[n0+3], 12);

    // Backpressure: fill FIFO, hold, release
    n0 = log_data.size();
    mem_ready = 1'b0;
    start_session();
    for (int k = 1; k <= 4; k++)
      send(3'd0, 7'h13, 3'd0, 1'b0, 5'(k), 5'd0, 5'd0, 32'(k), 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 0);
      chk("stall_we", 32'(mem_we), 1);
      chk("stall_addr", 32'(mem_addr), 0);
      chk("stall_data", mem_wdata, (32'd1 << 20) | (32'd1 << 7) | 32'h13);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    send(3'd0, 7'h13, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd5, 1'b1);
    wait_done();
    chk("bp_cnt", log_data.size() - n0, 5);
    for (int k = 0; k < 5; k++) begin
      chk("bp_addr", log_addr[n0+k], 32'(4 * k));
      chk("bp_data", log_data[n0+k], (32'(k + 1) << 20) | (32'(k + 1) << 7) | 32'h13);
    end

    // Illegal formats, clear priority, rejected last
    n0 = log_data.size();
    start_session();
    send(3'd6, 7'h13, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd1, 1'b0);
    @(negedge clk);
    chk("ill_err_set", 32'(err), 1);
    @(posedge clk); #1;
    clr_err = 1'b1;
    send(3'd7, 7'h13, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd1, 1'b0);
    clr_err = 1'b0;
    @(negedge clk);
    chk("clr_priority", 32'(err), 0);
    @(posedge clk); #1;
    send(3'd0, 7'h13, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'd9, 1'b0);
    send(3'd6, 7'h13, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd1, 1'b1);
    wait_done();
    chk("ill_cnt", log_data.size() - n0, 1);
    chk("ill_data", log_data[n0], 32'h0090_0493);
    chk("ill_err_sticky", 32'(err), 1);
    pulse_clr();
    chk("ill_err_clr", 32'(err), 0);

    // Immediate out of the I range
    n0 = log_data.size();
    start_session();
    send(3'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
    @(negedge clk);
`ifdef ENC_RANGE_CHECK_EN
    chk("rng_err", 32'(err), 1);
`else
    chk("rng_err", 32'(err), 0);
`endif
    @(posedge clk); #1;
    send(3'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1);
    wait_done();
`ifdef ENC_RANGE_CHECK_EN
    chk("rng_cnt", log_data.size() - n0, 1);
    chk("rng_addr", log_addr[n0], 0);
    chk("rng_data", log_data[n0], 32'h0010_0093);
`else
    chk("rng_cnt", log_data.size() - n0, 2);
    chk("rng_trunc", log_data[n0], 32'h8000_0093);
    chk("rng_addr", log_addr[n0+1], 4);
`endif
    pulse_clr();
    chk("rng_clr", 32'(err), 0);

    // Randomized sessions with random backpressure and clears
    stop_rand = 1'b0;
    fork
      begin
        for (int s = 0; s < 8; s++) begin
          int n;
          n = $urandom_range(1, 20);
          start_session();
          for (int k = 0; k < n; k++) begin
            int r;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            r = $urandom_range(0, 19);
            fmt = (r == 0) ? 3'd6 : (r == 1) ? 3'd7 : 3'($urandom_range(0, 5));
            send(fmt, 7'($urandom), 3'($urandom), (fmt == 3'd5) ? 1'($urandom) : 1'b0,
                 5'($urandom), 5'($urandom), 5'($urandom), rand_imm(fmt), k == n - 1);
          end
          wait_done();
        end
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk); #1;
          mem_ready = ($urandom_range(0, 2) != 0);
          clr_err   = ($urandom_range(0, 15) == 0);
        end
        mem_ready = 1'b1;
        clr_err   = 1'b0;
      end
    join

    // Reset during DRAIN with words queued
    mem_ready = 1'b0;
    start_session();
    for (int k = 0; k < 3; k++)
      send(3'd0, 7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'(k), k == 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(mem_we), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    n0 = log_data.size();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("arst_no_write", log_data.size() - n0, 0);
    start_session();
    send(3'd4, 7'h37, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1234_5000, 1'b1);
    wait_done();
    chk("post_rst_cnt", log_data.size() - n0, 1);
    chk("post_rst_addr", log_addr[n0], 0);
    chk("post_rst_data", log_data[n0], 32'h1234_53B7);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

RV32I instruction encoder and instruction-memory loader. Converts field-level instruction descriptions into 32-bit machine words, which the control-unit path can decode. Buffers the words in a small FIFO and writes them sequentially into instruction memory through a ready/valid write port. Used by the boot/test-load path to place programs into instruction memory before the core is released.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- ADDR_WIDTH, 12: byte-address width of the memory port.
- BASE_ADDR, 0: first write address; word-aligned.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a load session from IDLE.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder accepts fields this cycle.
- in_last  in  1  marks the final instruction of the session.
- in_fmt  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 R; others are illegal.
- in_op  in  7  opcode, placed in bits [6:0].
- in_funct3  in  3  funct3; ignored for U/J.
- in_funct7_5  in  1  instruction bit 30 for R format; 0 elsewhere.
- in_rd, in_rs1, in_rs2  in  5 each  register indices; unused ones ignored.
- in_imm  in  32  signed byte-offset immediate; for U, the full upper value.
- mem_we  out  1  write valid (FIFO non-empty).
- mem_ready  in  1  memory accepts the write.
- mem_addr  out  ADDR_WIDTH  byte address of the head word.
- mem_wdata  out  32  head word.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky: an instruction was rejected.
- clr_err  in  1  clears err.

## Operation
- FSM states:
  - IDLE: in_ready=0. On start, go to LOAD and set the address counter to BASE_ADDR.
  - LOAD: in_ready = !full. On accept with in_last=1, go to DRAIN.
  - DRAIN: in_ready=0. When the FIFO is empty and no transfer is pending, go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Accept: in_valid && in_ready. The word is encoded combinationally and pushed at that edge.
- Encoding uses standard RV32I bit placement:
  - I: imm[11:0] goes to [31:20].
  - S: imm[11:5] goes to [31:25]; imm[4:0] goes to [11:7].
  - B: imm[12|10:5] goes to [31:25]; imm[4:1|11] goes to [11:7].
  - J: imm[20|10:1|11|19:12] goes to [31:12].
  - U: imm[31:12] goes to [31:12].
  - R: in_funct7_5 goes to bit 30; all other funct7 bits are 0.
- Illegal in_fmt is rejected: no push and err is set. This applies regardless of the macro.
- Transfer: mem_we && mem_ready. On transfer, pop the FIFO and increment the address by 4. The address wraps modulo 2^ADDR_WIDTH.
- Push and pop in the same cycle are both allowed when the FIFO is non-empty and non-full. No bypass when full.
- in_last on a rejected instruction still moves the FSM to DRAIN.
- clr_err has priority over a same-cycle set.
- start outside IDLE is ignored.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, err=0. The FIFO is empty and the FSM is in IDLE.
- Latency: a word accepted at edge N is on mem_we/mem_wdata from cycle N+1.
- Throughput: one word per cycle while mem_ready stays high.
- mem_addr, mem_wdata and mem_we hold stable while mem_we=1 and mem_ready=0.
- err is set at the edge of the rejecting accept.
- Reset asserted mid-session aborts immediately: FIFO contents are discarded and no further writes occur.

## Configuration
- ENC_RANGE_CHECK_EN defined: immediates are range-checked. An out-of-range instruction is consumed, not pushed, and sets err; the address does not advance. Limits:
  - I/S: signed 12-bit.
  - B: signed 13-bit and even.
  - J: signed 21-bit and even.
  - U: imm[11:0] must be 0.
- ENC_RANGE_CHECK_EN undefined: immediates are silently truncated to the format's fields. err is set only by an illegal in_fmt.

## Test plan
- start, then I-format addi (op=0x13, rd=1, rs1=0, imm=5, last) -> mem_we next cycle with addr=BASE_ADDR and data 0x00500093. Then done pulses and the FSM returns to IDLE.
- R-format add (op=0x33, rd=3, rs1=1, rs2=2, funct7_5=0), then sub (funct7_5=1) -> 0x002081B3 at addr 0 and 0x402081B3 at addr 4.
- S-format sw (op=0x23, f3=2, rs1=1, rs2=2, imm=8), then B-format beq (op=0x63, imm=-4) -> 0x0020A423, then 0xFE000EE3.
- Hold mem_ready=0 and push 5 instructions with DEPTH=4 -> in_ready drops after the 4th. Outputs stay stable. Release mem_ready -> 5 writes at addresses 0,4,8,12,16, in order.
- With ENC_RANGE_CHECK_EN: addi imm=2048 -> no write, err=1, and the next valid word is written at the unadvanced address. clr_err -> err=0.
- Assert rst_n low with 3 words queued mid-DRAIN -> mem_we=0 immediately, state IDLE, no done pulse.
